// File: rtl/fx2_stream_bridge.sv
// Bridge between the FX2 slave-FIFO port layer and user byte streams:
// receive drains FIFO2 combinationally, transmit is buffered and burst-written to FIFO4.
module fx2_stream_bridge #(
    parameter int TX_DEPTH  = 16,
    parameter int TX_THRESH = 8,
    parameter int PKT_MAX   = 512,
    parameter int TIMEOUT   = 255
) (
    input  logic       FIFO_CLK,
    input  logic       FIFO_RST,
    input  logic       FIFO2_data_available,
    input  logic       FIFO4_ready_to_accept_data,
    input  logic [7:0] FIFO_DATAIN,
    output logic [7:0] FIFO_DATAOUT,
    output logic       FIFO_RD,
    output logic       FIFO_WR,
    output logic       FIFO_PKTEND,
    output logic [1:0] FIFO_FIFOADR,
    output logic       FIFO_DATAIN_OE,
    output logic       FIFO_DATAOUT_OE,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_flush
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int PW = $clog2(PKT_MAX);
    localparam int TW = 16;

    localparam logic [AW:0]   DEPTH_C  = TX_DEPTH[AW:0];
    localparam logic [AW:0]   THRESH_C = TX_THRESH[AW:0];
    localparam logic [TW-1:0] TMO_C    = TIMEOUT[TW-1:0];

    localparam logic [1:0] ADR_FIFO2 = 2'b00;
    localparam logic [1:0] ADR_FIFO4 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN_TX,
        S_TX,
        S_PKTEND,
        S_TURN_RX
    } state_t;

    state_t          state;
    logic [7:0]      mem [TX_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic [PW-1:0]   pkt_cnt;
    logic [PW-1:0]   pkt_next;
    logic [TW-1:0]   tmo_cnt;
    logic            flush_pend;
    logic            push;
    logic            pop;
    logic            pend;
    logic            go;

    assign tx_ready     = (count != DEPTH_C);
    assign push         = tx_valid & tx_ready;
    assign pop          = FIFO_WR;
    assign FIFO_DATAOUT = mem[rd_ptr];
    assign rx_data      = FIFO_DATAIN;

    assign pend = (count != '0) | (pkt_cnt != '0);
    assign go   = pend & FIFO4_ready_to_accept_data &
                  ((count >= THRESH_C) | (tmo_cnt == TMO_C) | flush_pend);

    // pkt_cnt wraps at PKT_MAX on its own; FX2 autocommits full packets.
    assign pkt_next = pop ? pkt_cnt + 1'b1 : pkt_cnt;

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Bus-facing strobes are decoded from state and live inputs so receive stays zero-latency.
    always_comb begin
        FIFO_RD         = 1'b0;
        FIFO_WR         = 1'b0;
        FIFO_PKTEND     = 1'b0;
        FIFO_FIFOADR    = ADR_FIFO2;
        FIFO_DATAIN_OE  = 1'b0;
        FIFO_DATAOUT_OE = 1'b0;
        rx_valid        = 1'b0;
        if (FIFO_RST) begin
            FIFO_DATAIN_OE = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    FIFO_DATAIN_OE = 1'b1;
                    rx_valid       = FIFO2_data_available & ~go;
                    FIFO_RD        = rx_valid & rx_ready;
                end
                S_TURN_TX: FIFO_FIFOADR = ADR_FIFO4;
                S_TX: begin
                    FIFO_FIFOADR    = ADR_FIFO4;
                    FIFO_DATAOUT_OE = 1'b1;
                    FIFO_WR         = (count != '0) & FIFO4_ready_to_accept_data;
                end
                S_PKTEND: begin
                    FIFO_FIFOADR = ADR_FIFO4;
                    FIFO_PKTEND  = 1'b1;
                end
                default: FIFO_FIFOADR = ADR_FIFO2;
            endcase
        end
    end

    // NOTE: the byte storage has no reset; pointers and count define what is valid,
    // so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge FIFO_CLK) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge FIFO_CLK) begin
        if (FIFO_RST) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_cnt    <= '0;
            tmo_cnt    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            pkt_cnt <= pkt_next;

            if (!pend || state == S_TX)  tmo_cnt <= '0;
            else if (tmo_cnt != TMO_C)   tmo_cnt <= tmo_cnt + 1'b1;

            // A flush with nothing pending self-clears on the next cycle.
            if (tx_flush)   flush_pend <= 1'b1;
            else if (!pend) flush_pend <= 1'b0;

            case (state)
                S_IDLE:    if (go) state <= S_TURN_TX;
                S_TURN_TX: state <= S_TX;
                S_TX: begin
                    if (!FIFO4_ready_to_accept_data)
                        state <= S_TURN_RX;
                    else if (count_next == '0)
                        state <= (pkt_next != '0) ? S_PKTEND : S_TURN_RX;
                end
                S_PKTEND: begin
                    pkt_cnt    <= '0;
                    flush_pend <= 1'b0;
                    state      <= S_TURN_RX;
                end
                S_TURN_RX: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fx2_stream_bridge.md
Name: fx2_stream_bridge

Overview:
- Sits between the positive-logic FX2 slave-FIFO port layer and user logic.
- Presents a byte receive stream drained from FIFO2 and a buffered byte transmit stream written to FIFO4.
- Owns FIFOADR switching, bus turnaround, data-bus output enables, and short-packet commit via PKTEND.
- User logic never touches FX2 control signals directly.

Parameters:
- TX_DEPTH, 16: transmit buffer depth in bytes; power of 2, minimum 4.
- TX_THRESH, 8: buffered byte count that starts a transmit burst; range 1..TX_DEPTH.
- PKT_MAX, 512: FX2 endpoint packet size in bytes; power of 2.
- TIMEOUT, 255: idle cycles with pending transmit data before a forced flush; range 1..65535.

Ports:
- FIFO_CLK  in  1  single clock, FX2 interface clock; all logic on its rising edge.
- FIFO_RST  in  1  synchronous, active-high reset.
- FIFO2_data_available  in  1  FIFO2 holds at least one byte.
- FIFO4_ready_to_accept_data  in  1  FIFO4 is not full.
- FIFO_DATAIN  in  8  FX2 data bus, read direction.
- FIFO_DATAOUT  out  8  FX2 data bus, write direction.
- FIFO_RD  out  1  read strobe; the byte is consumed on the edge where FIFO_RD=1 and FIFO2_data_available=1.
- FIFO_WR  out  1  write strobe.
- FIFO_PKTEND  out  1  commit short packet.
- FIFO_FIFOADR  out  2  2'b00 selects FIFO2, 2'b10 selects FIFO4.
- FIFO_DATAIN_OE  out  1  FX2 drives the bus.
- FIFO_DATAOUT_OE  out  1  FPGA drives the bus.
- rx_data  out  8  received byte; equals FIFO_DATAIN.
- rx_valid  out  1  rx_data is valid this cycle.
- rx_ready  in  1  user accepts rx_data.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit buffer not full.
- tx_flush  in  1  one-cycle request to commit all pending transmit data as a packet.

Behaviour:
- Reset (FIFO_RST=1 at an edge) clears:
  - state to IDLE;
  - buffer pointers and count to 0;
  - pkt_cnt, tmo_cnt and flush_pend to 0.
- While FIFO_RST=1:
  - FIFO_RD, FIFO_WR, FIFO_PKTEND, FIFO_DATAOUT_OE and rx_valid are 0;
  - FIFO_FIFOADR is 00 and FIFO_DATAIN_OE is 1.
- Reset mid-burst abandons any uncommitted FX2 packet and discards buffered bytes.
- Transmit buffer:
  - TX_DEPTH x 8, first-word-fall-through;
  - push = tx_valid & tx_ready; pop = FIFO_WR;
  - simultaneous push and pop leaves count unchanged;
  - tx_ready = (count != TX_DEPTH);
  - pointers wrap modulo TX_DEPTH;
  - FIFO_DATAOUT = buffer head.
- pend = (count != 0) | (pkt_cnt != 0).
- go = pend & FIFO4_ready_to_accept_data & ((count >= TX_THRESH) | (tmo_cnt == TIMEOUT) | flush_pend).
- tx_flush sets flush_pend.
  - If pend=0 at that moment, nothing is sent (no zero-length packet) and flush_pend clears the next cycle.
- tmo_cnt:
  - increments, saturating at TIMEOUT, while pend=1 and state != TX;
  - clears when pend=0 or when in TX.
- FSM states and outputs:
  - IDLE: FIFOADR=00, DATAIN_OE=1, rx_valid = FIFO2_data_available & ~go, FIFO_RD = rx_valid & rx_ready.
    - go=1 -> TURN_TX. go has priority over receive; receiving stops in the same cycle.
  - TURN_TX: FIFOADR=10, DATAIN_OE=0, DATAOUT_OE=0; lasts 1 cycle -> TX.
  - TX: FIFOADR=10, DATAOUT_OE=1, FIFO_WR = (count != 0) & FIFO4_ready_to_accept_data.
    - Each write increments pkt_cnt modulo PKT_MAX. FX2 autocommits full packets, so wrap to 0 needs no PKTEND.
    - count=0 with pkt_cnt != 0 -> PKTEND.
    - count=0 with pkt_cnt=0 -> TURN_RX.
    - FIFO4 not ready -> TURN_RX. pkt_cnt is kept and the packet resumes on a later burst.
    - The exit check uses count after this cycle's pop.
  - PKTEND: FIFOADR=10, FIFO_PKTEND=1 for exactly 1 cycle; pkt_cnt and flush_pend clear -> TURN_RX.
  - TURN_RX: FIFOADR=00, DATAIN_OE=0, no strobes; lasts 1 cycle -> IDLE.
- FIFO_RD and FIFO_WR are never 1 in the same cycle.
- DATAIN_OE and DATAOUT_OE are never both 1.
- Latency:
  - receive is zero-latency pass-through;
  - at least 2 cycles from go to the first FIFO_WR.

Test Plan:
- After reset, 5 bytes 0x11..0x15 in FIFO2 with rx_ready=1 -> 5 rx_valid&FIFO_RD cycles in order; FIFOADR=00 throughout.
- FIFO2 holds 0xA0,0xA1 and rx_ready is low for 3 cycles, then high -> no FIFO_RD while rx_ready=0; 0xA0 is held on rx_data; both bytes delivered in order with no loss.
- Push 8 bytes 0x00..0x07 (TX_THRESH=8) -> TURN_TX, 8 FIFO_WR cycles with data 0x00..0x07, then PKTEND 1 cycle, TURN_RX, IDLE.
- Push 3 bytes and wait -> after 255 idle cycles a burst of 3 writes + PKTEND. Repeat with tx_flush instead -> burst starts within 1 cycle of the request.
- FIFO4 not ready after 2 of 8 writes -> TURN_RX with pkt_cnt=2. When FIFO4 is ready again the remaining 6 writes follow, then one PKTEND (packet of 8).
- Send 512 bytes continuously -> no PKTEND at 512. With 1 more byte plus tx_flush -> exactly 1 write then PKTEND. tx_flush with nothing pending -> no FIFO_WR and no PKTEND.
